// File: rtl/layer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_seq_pkg
// Brief    : Shared state encoding and counter-width helpers for layer_sequencer
// Revision : 1.0
// ============================================================================
package layer_seq_pkg;

  localparam int C_STATE_W = 2;

  typedef enum logic [C_STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Counter that must be able to hold the value n itself
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Index into n entries (0..n-1)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/layer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer_if
// Brief    : Upstream element stream and downstream activation stream
// Revision : 1.0
// ============================================================================
interface layer_sequencer_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  // master: the sequencer; slave: the producer/consumer around it
  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

endinterface
`default_nettype wire

// File: rtl/act_buf.sv
`default_nettype none
// ============================================================================
// Module   : act_buf
// Brief    : Per-neuron activation capture registers with done mask and read port
// Revision : 1.0
// ============================================================================
module act_buf
  import layer_seq_pkg::*;
#(
  parameter int NUM_NEURON = 30,
  parameter int DATA_WIDTH = 16
) (
  input  wire                             clk,
  input  wire                             rst,
  input  wire [NUM_NEURON*DATA_WIDTH-1:0] i_nrn_out,
  input  wire [NUM_NEURON-1:0]            i_cap,
  input  wire                             i_force_zero,
  input  wire                             i_clear,
  input  wire [idx_w(NUM_NEURON)-1:0]     i_rd_idx,
  output logic [NUM_NEURON-1:0]           o_done,
  output logic [DATA_WIDTH-1:0]           o_rd_data
);

  logic [DATA_WIDTH-1:0] w_buf [NUM_NEURON];

  for (genvar k = 0; k < NUM_NEURON; k++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_val;
    logic                  r_done;

    // A capture in the timeout cycle wins over the forced zero
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_val  <= '0;
        r_done <= 1'b0;
      end else if (i_clear) begin
        r_done <= 1'b0;
      end else if (i_cap[k]) begin
        r_val  <= i_nrn_out[k*DATA_WIDTH +: DATA_WIDTH];
        r_done <= 1'b1;
      end else if (i_force_zero && !r_done) begin
        r_val  <= '0;
      end
    end

    assign w_buf[k]  = r_val;
    assign o_done[k] = r_done;
  end

  assign o_rd_data = w_buf[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Brief    : Streams an input vector to a neuron layer, collects and serializes outputs
// Revision : 1.0
// ============================================================================
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int NUM_INPUT    = 784,
  parameter int NUM_NEURON   = 30,
  parameter int DATA_WIDTH   = 16,
  parameter int WAIT_TIMEOUT = 64
) (
  input  wire                             clk,
  input  wire                             rst,
  layer_sequencer_if.master               io,
  output logic [DATA_WIDTH-1:0]           nrn_data,
  output logic                            nrn_valid,
  input  wire [NUM_NEURON*DATA_WIDTH-1:0] nrn_out,
  input  wire [NUM_NEURON-1:0]            nrn_outvalid,
  output logic                            busy,
  output logic                            err
);

  localparam int C_IN_CNT_W   = cnt_w(NUM_INPUT);
  localparam int C_WAIT_CNT_W = cnt_w(WAIT_TIMEOUT);
  localparam int C_IDX_W      = idx_w(NUM_NEURON);

  state_t                  r_state, w_state_nxt;
  logic [C_IN_CNT_W-1:0]   r_in_cnt;
  logic [C_WAIT_CNT_W-1:0] r_wait_cnt;
  logic [C_IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0]   r_nrn_data;
  logic                    r_nrn_valid;
  logic                    r_err;

  logic                    w_beat, w_last_beat, w_cap_win, w_stray;
  logic                    w_timeout, w_final_hs, w_out_valid;
  logic [NUM_NEURON-1:0]   w_cap, w_done, w_done_nxt;
  logic [DATA_WIDTH-1:0]   w_rd_data;

  assign io.in_ready = (r_state == ST_IDLE) || (r_state == ST_FEED);
  assign w_beat      = io.in_valid && io.in_ready;
  assign w_last_beat = (r_in_cnt + C_IN_CNT_W'(1)) == C_IN_CNT_W'(NUM_INPUT);

  // Neuron results are taken while waiting, and on the cycle of the final beat
  assign w_cap_win  = (r_state == ST_WAIT) || (w_beat && w_last_beat);
  assign w_cap      = nrn_outvalid & ~w_done & {NUM_NEURON{w_cap_win}};
  assign w_stray    = |(nrn_outvalid & ~w_cap);
  assign w_done_nxt = w_done | w_cap;

  assign w_out_valid = (r_state == ST_DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_final_hs  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_beat) w_state_nxt = w_last_beat ? ST_WAIT : ST_FEED;
      end
      ST_FEED: begin
        if (w_beat && w_last_beat) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (&w_done_nxt) begin
          w_state_nxt = ST_DRAIN;
        end else if (r_wait_cnt == C_WAIT_CNT_W'(WAIT_TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (io.out_ready && (r_idx == C_IDX_W'(NUM_NEURON - 1))) begin
          w_final_hs  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nrn_data  <= '0;
      r_nrn_valid <= 1'b0;
      r_err       <= 1'b0;
      r_in_cnt    <= '0;
      r_wait_cnt  <= '0;
      r_idx       <= '0;
    end else begin
      r_nrn_valid <= w_beat;
      if (w_beat) r_nrn_data <= io.in_data;
      r_err <= w_timeout || w_stray;
      if (w_final_hs) begin
        r_in_cnt   <= '0;
        r_wait_cnt <= '0;
        r_idx      <= '0;
      end else begin
        if (w_beat)                    r_in_cnt   <= r_in_cnt + C_IN_CNT_W'(1);
        if (r_state == ST_WAIT)        r_wait_cnt <= r_wait_cnt + C_WAIT_CNT_W'(1);
        if (w_out_valid && io.out_ready) r_idx    <= r_idx + C_IDX_W'(1);
      end
    end
  end

  act_buf #(
    .NUM_NEURON (NUM_NEURON),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_act_buf (
    .clk          (clk),
    .rst          (rst),
    .i_nrn_out    (nrn_out),
    .i_cap        (w_cap),
    .i_force_zero (w_timeout),
    .i_clear      (w_final_hs),
    .i_rd_idx     (r_idx),
    .o_done       (w_done),
    .o_rd_data    (w_rd_data)
  );

  // Outside DRAIN the read port may point at stale data; keep it off the bus
  assign io.out_data  = w_out_valid ? w_rd_data : '0;
  assign io.out_valid = w_out_valid;
  assign io.out_last  = w_out_valid && (r_idx == C_IDX_W'(NUM_NEURON - 1));

  assign nrn_data  = r_nrn_data;
  assign nrn_valid = r_nrn_valid;
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_sequencer
// Brief    : Directed self-checking bench for layer_sequencer (4 inputs, 3 neurons)
// Revision : 1.0
// ============================================================================
module tb_layer_sequencer;

  localparam int NUM_INPUT    = 4;
  localparam int NUM_NEURON   = 3;
  localparam int DATA_WIDTH   = 16;
  localparam int WAIT_TIMEOUT = 8;

  logic                             clk;
  logic                             rst;
  logic [DATA_WIDTH-1:0]            nrn_data;
  logic                             nrn_valid;
  logic [NUM_NEURON*DATA_WIDTH-1:0] nrn_out;
  logic [NUM_NEURON-1:0]            nrn_outvalid;
  logic                             busy;
  logic                             err;

  int errors = 0;
  int checks = 0;

  layer_sequencer_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  layer_sequencer #(
    .NUM_INPUT    (NUM_INPUT),
    .NUM_NEURON   (NUM_NEURON),
    .DATA_WIDTH   (DATA_WIDTH),
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io           (bus),
    .nrn_data     (nrn_data),
    .nrn_valid    (nrn_valid),
    .nrn_out      (nrn_out),
    .nrn_outvalid (nrn_outvalid),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Four back-to-back beats; returns at the negedge of the first WAIT cycle
  task automatic send_vec(input logic [15:0] d0, d1, d2, d3);
    logic [15:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      @(negedge clk);
      check("in_ready_feed", bus.in_ready, 1);
    end
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_wait", bus.in_ready, 0);
  endtask

  task automatic drain3(input logic [15:0] e0, e1, e2, input logic err0);
    logic [15:0] e [3];
    e = '{e0, e1, e2};
    for (int j = 0; j < 3; j++) begin
      cyc();
      nrn_outvalid  = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("drain_valid", bus.out_valid, 1);
      check("drain_data", bus.out_data, e[j]);
      check("drain_last", bus.out_last, (j == 2));
      if (j == 0) check("drain_err0", err, err0);
      if (j == 1) check("drain_err1", err, 0);
    end
    cyc();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("drain_busy_fall", busy, 0);
    check("drain_valid_fall", bus.out_valid, 0);
  endtask

  initial begin
    logic [15:0] exp_d [5];
    logic        exp_l [5];
    logic        pat   [5];
    int          hs;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    nrn_out       = '0;
    nrn_outvalid  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_nrn_valid", nrn_valid, 0);
    check("rst_nrn_data", nrn_data, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    // Vector 1,2,3,4 back-to-back, neurons answer on separate cycles
    cyc();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd1;
    @(negedge clk);
    check("v1_nrn_valid_lat", nrn_valid, 0);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      bus.in_data = 16'(i);
      @(negedge clk);
      check("v1_nrn_valid", nrn_valid, 1);
      check("v1_nrn_data", nrn_data, i - 1);
      check("v1_busy", busy, 1);
    end
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("v1_nrn_valid4", nrn_valid, 1);
    check("v1_nrn_data4", nrn_data, 4);
    check("v1_in_ready_drop", bus.in_ready, 0);
    nrn_out = {16'h0030, 16'h0020, 16'h0010};
    cyc();
    nrn_outvalid = 3'b001;
    @(negedge clk);
    check("v1_nrn_valid_end", nrn_valid, 0);
    cyc();
    nrn_outvalid = 3'b000;
    cyc();
    nrn_outvalid = 3'b010;
    cyc();
    nrn_outvalid = 3'b100;
    drain3(16'h0010, 16'h0020, 16'h0030, 1'b0);

    // Back-pressure in DRAIN; upstream beats offered meanwhile must be refused
    send_vec(16'd5, 16'd6, 16'd7, 16'd8);
    nrn_out      = {16'h000C, 16'h000B, 16'h000A};
    nrn_outvalid = 3'b111;
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_d = '{16'h000A, 16'h000B, 16'h000B, 16'h000B, 16'h000C};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    hs    = 0;
    for (int j = 0; j < 5; j++) begin
      cyc();
      nrn_outvalid  = '0;
      bus.out_ready = pat[j];
      bus.in_valid  = (j >= 1) && (j <= 3);
      bus.in_data   = 16'h0099;
      @(negedge clk);
      check("bp_valid", bus.out_valid, 1);
      check("bp_data", bus.out_data, exp_d[j]);
      check("bp_last", bus.out_last, exp_l[j]);
      check("bp_in_ready", bus.in_ready, 0);
      if (j >= 2) check("bp_no_beat", nrn_valid, 0);
      if (j == 0) check("bp_err", err, 0);
      if (bus.out_valid && bus.out_ready) hs++;
    end
    cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_busy_fall", busy, 0);
    check("bp_handshakes", hs, 3);

    // Neuron 2 silent: timeout after 8 WAIT cycles, its slot reads zero
    send_vec(16'd9, 16'd10, 16'd11, 16'd12);
    nrn_out      = {16'hBEEF, 16'h2222, 16'h1111};
    nrn_outvalid = 3'b001;
    for (int c = 1; c < WAIT_TIMEOUT; c++) begin
      cyc();
      nrn_outvalid = (c == 1) ? 3'b010 : 3'b000;
      @(negedge clk);
      check("to_wait_valid", bus.out_valid, 0);
      if (c == WAIT_TIMEOUT - 1) check("to_err_early", err, 0);
    end
    drain3(16'h1111, 16'h2222, 16'h0000, 1'b1);

    // Neuron 1 pulses twice: second pulse flagged, first value kept
    send_vec(16'd13, 16'd14, 16'd15, 16'd16);
    nrn_out      = {16'h0C03, 16'h0A01, 16'h0B02};
    nrn_outvalid = 3'b011;
    cyc();
    nrn_out[31:16] = 16'hDEAD;
    nrn_outvalid   = 3'b010;
    @(negedge clk);
    check("dup_err_before", err, 0);
    cyc();
    nrn_outvalid = 3'b100;
    @(negedge clk);
    check("dup_err_pulse", err, 1);
    drain3(16'h0B02, 16'h0A01, 16'h0C03, 1'b0);

    // Asynchronous reset after the second beat, then a clean vector
    cyc();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0077;
    cyc();
    bus.in_data  = 16'h0078;
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("ar_pre_busy", busy, 1);
    #1 rst = 1'b0;
    #1;
    check("ar_nrn_valid", nrn_valid, 0);
    check("ar_nrn_data", nrn_data, 0);
    check("ar_busy", busy, 0);
    check("ar_in_ready", bus.in_ready, 1);
    check("ar_out_valid", bus.out_valid, 0);
    cyc();
    rst = 1'b1;
    send_vec(16'h0021, 16'h0022, 16'h0023, 16'h0024);
    nrn_out      = {16'h0043, 16'h0042, 16'h0041};
    nrn_outvalid = 3'b111;
    drain3(16'h0041, 16'h0042, 16'h0043, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_INPUT, default 784: input-vector elements streamed to every neuron of the layer per inference.
REQ-002 Parameter NUM_NEURON, default 30: neurons in the layer.
REQ-003 Parameter DATA_WIDTH, default 16: element/activation width.
REQ-004 Parameter WAIT_TIMEOUT, default 64: max cycles in WAIT before forced drain.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 in_data  in  DATA_WIDTH  upstream activation element.
REQ-008 in_valid / in_ready  in / out  1  upstream handshake.
REQ-009 nrn_data  out  DATA_WIDTH  element broadcast to all neurons' myinput.
REQ-010 nrn_valid  out  1  broadcast to all neurons' myinputValid.
REQ-011 nrn_out  in  NUM_NEURON*DATA_WIDTH  concatenated neuron outputs, neuron k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 nrn_outvalid  in  NUM_NEURON  per-neuron outvalid pulses.
REQ-013 out_data  out  DATA_WIDTH  serialized layer activation.
REQ-014 out_valid / out_ready  out / in  1  downstream handshake.
REQ-015 out_last  out  1  high with final element (neuron NUM_NEURON-1).
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 err  out  1  one-cycle pulse on timeout or on stray outvalid.

Function
REQ-018 FSM states: IDLE, FEED, WAIT, DRAIN.
REQ-019 in_ready = 1 in IDLE and in FEED; 0 in WAIT and DRAIN.
REQ-020 Beat accepted = in_valid & in_ready; in IDLE it moves to FEED and counts as element 0.
REQ-021 Each accepted beat drives nrn_data <= in_data, nrn_valid <= 1 on the next edge (latency 1); nrn_valid = 0 on cycles with no beat.
REQ-022 in_cnt (clog2(NUM_INPUT)+1 bits) increments per beat; the beat making in_cnt == NUM_INPUT moves FEED->WAIT, in_ready drops the following cycle.
REQ-023 Gaps in in_valid allowed; no timeout in FEED.
REQ-024 In WAIT and FEED's final cycle, each nrn_outvalid[k] pulse captures nrn_out slice k into buf[k] and sets done[k].
REQ-025 WAIT->DRAIN when done is all-ones (including same-cycle captures), or when wait_cnt reaches WAIT_TIMEOUT.
REQ-026 On timeout: err pulses once; buf[k] with done[k]=0 is forced to 0.
REQ-027 nrn_outvalid[k] while done[k] already set, or in IDLE/DRAIN: ignored for data, err pulses.
REQ-028 DRAIN: out_valid = 1, out_data = buf[idx]; idx advances only on out_valid & out_ready; out_data stable while stalled.
REQ-029 out_last = (idx == NUM_NEURON-1) & out_valid.
REQ-030 Final handshake: DRAIN->IDLE; in_cnt, wait_cnt, idx, done cleared; next vector accepted from the cycle after.
REQ-031 Input beat arriving while in DRAIN: not accepted (in_ready = 0), no overlap between vectors.

Reset
REQ-032 rst low, asynchronously: state IDLE, in_ready 1 after release, nrn_valid 0, nrn_data 0, out_valid 0, out_last 0, busy 0, err 0, all counters/done/buf cleared.
REQ-033 Reset mid-FEED/WAIT/DRAIN aborts the vector; partial data never appears on out_data.

Structure
REQ-034 Shared package layer_seq_pkg holds the state enum and width helper constants (cnt widths via clog2).
REQ-035 One sub-module act_buf: NUM_NEURON x DATA_WIDTH capture registers with done mask, forced-zero on timeout, and indexed read port.

Verification (NUM_INPUT=4, NUM_NEURON=3, DATA_WIDTH=16, WAIT_TIMEOUT=8)
REQ-036 Stream 1,2,3,4 back-to-back -> nrn_valid high 4 cycles, 1 cycle late, nrn_data 1..4; in_ready 0 after 4th beat.
REQ-037 Neurons pulse outvalid 0x0010/0x0020/0x0030 on different cycles, out_ready=1 -> out_data 0x0010,0x0020,0x0030, out_last on third, busy falls after.
REQ-038 out_ready toggles 1,0,0,1,1 in DRAIN -> each element held while stalled, exactly 3 handshakes, no duplication.
REQ-039 Neuron 2 never pulses -> err pulse 8 cycles into WAIT, outputs neuron0, neuron1, 0x0000.
REQ-040 Neuron 1 pulses twice -> err pulse on second, buf[1] keeps first value.
REQ-041 rst low after 2nd beat -> outputs immediately reset; after release a full 4-beat vector processes normally.
